alu_reservation_station: RTL and testbench
==========================================

ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter: DEPTH, 4, number of RS entries (power of two, 2..8).
REQ-002 Parameter: TAG_W, 4, ROB tag width; tag value 0 means "no dependency".
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 flush_i  input  1  mispredict flush; clears all entries.
REQ-006 issue_valid_i  input  1  issue request from decode/issue stage.
REQ-007 issue_packet_i  input  reservation_station_s  op, vj, vk, qj, qk, dest, address, fu_type, pc.
REQ-008 full_o  output  1  all DEPTH entries busy.
REQ-009 count_o  output  $clog2(DEPTH)+1  number of busy entries.
REQ-010 cdb_packet_i  input  cdb_packet_s  result broadcast (valid, rob_entry, data, exception).
REQ-011 fu_ready_i  input  1  ALU accepts a dispatch this cycle.
REQ-012 dispatch_valid_o  output  1  dispatch_* fields hold a ready instruction.
REQ-013 dispatch_op_o / dispatch_vj_o / dispatch_vk_o / dispatch_dest_o / dispatch_imm_o / dispatch_pc_o  output  4/32/32/TAG_W/32/32  operands of selected entry (imm = address field).

Function
REQ-014 Each entry SHALL store busy, op, vj, vk, qj, qk, dest, address, pc and an allocation-age rank.
REQ-015 Allocation SHALL occur when issue_valid_i && !full_o && !flush_i, writing the lowest-index free entry at the next edge.
REQ-016 issue_valid_i while full_o or flush_i SHALL be ignored (no state change, no error).
REQ-017 Incoming packet with qj!=0 matching a valid, non-exception CDB tag in the same cycle SHALL be stored with qj=0, vj=cdb data; likewise qk/vk.
REQ-018 Each busy entry with qj (qk) != 0 equal to a valid, non-exception CDB rob_entry SHALL capture data into vj (vk) and clear qj (qk) at the next edge.
REQ-019 CDB packets with exception=1 SHALL be ignored by all entries.
REQ-020 An entry SHALL be ready when busy, qj==0, qk==0.
REQ-021 dispatch_valid_o SHALL be combinational from registered state: 1 when any entry ready and flush_i=0.
REQ-022 Selected entry SHALL be the oldest ready entry by allocation order; dispatch_* SHALL reflect it; dispatch_* SHALL be 0 when dispatch_valid_o=0.
REQ-023 Handshake: on dispatch_valid_o && fu_ready_i the selected entry SHALL be freed at the next edge; fields SHALL be held stable while fu_ready_i=0.
REQ-024 An entry allocated or woken by CDB in cycle N SHALL be dispatchable no earlier than cycle N+1 (one-cycle minimum latency issue-to-dispatch).
REQ-025 Simultaneous dispatch and allocation SHALL both take effect; full_o is evaluated before the dispatch, so a full RS does not accept issue in the freeing cycle.
REQ-026 count_o SHALL update per edge: +1 on allocation, -1 on dispatch, unchanged on both.
REQ-027 full_o SHALL equal (count_o == DEPTH).
REQ-028 flush_i SHALL clear all busy bits at the next edge, overriding allocation, dispatch and CDB capture; count_o becomes 0.
REQ-029 Age ranks SHALL be maintained so order is preserved across arbitrary free/allocate interleaving.

Reset
REQ-030 While reset_i=0: all busy=0, count_o=0, full_o=0, dispatch_valid_o=0, all dispatch_* = 0, independent of clock.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately; first allocation after release SHALL go to entry 0.

Verification
REQ-032 Issue ADD vj=5 vk=7 qj=qk=0, fu_ready_i=1 -> next cycle dispatch_valid_o=1, vj=5, vk=7; following cycle count_o=0.
REQ-033 Issue qj=3 qk=0; later CDB rob_entry=3 data=0x1234 -> next cycle dispatch_vj_o=0x1234; CDB tag 3 with exception=1 -> no wake.
REQ-034 Issue qj=2 same cycle as CDB tag 2 data=9 -> stored vj=9, dispatched the following cycle.
REQ-035 Fill 4 entries, fu_ready_i=0 -> full_o=1, count_o=4, 5th issue ignored; fu_ready_i=1 with 5th held -> one dispatch, 5th accepted the cycle after.
REQ-036 Entries A (older, waiting) and B (younger, ready); wake A -> B dispatched first, A next; order oldest-first when both ready.
REQ-037 Three busy entries, flush_i=1 with simultaneous issue and CDB -> next cycle count_o=0, dispatch_valid_o=0; reset_i low mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// rtl/alu_reservation_station_pkg.sv - issue and CDB packet types for the ALU reservation station
package alu_reservation_station_pkg;

   localparam int RS_TAG_W = 4;

   typedef struct packed {
      logic [3:0]          op;
      logic [31:0]         vj;
      logic [31:0]         vk;
      logic [RS_TAG_W-1:0] qj;
      logic [RS_TAG_W-1:0] qk;
      logic [RS_TAG_W-1:0] dest;
      logic [31:0]         address;
      logic [1:0]          fu_type;
      logic [31:0]         pc;
   } reservation_station_s;

   typedef struct packed {
      logic                valid;
      logic [RS_TAG_W-1:0] rob_entry;
      logic [31:0]         data;
      logic                exception;
   } cdb_packet_s;

endpackage

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station with CDB wakeup and oldest-ready dispatch
module alu_reservation_station
   import alu_reservation_station_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = RS_TAG_W
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       flush_i,
   input  logic                       issue_valid_i,
   input  reservation_station_s       issue_packet_i,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     count_o,
   input  cdb_packet_s                cdb_packet_i,
   input  logic                       fu_ready_i,
   output logic                       dispatch_valid_o,
   output logic [3:0]                 dispatch_op_o,
   output logic [31:0]                dispatch_vj_o,
   output logic [31:0]                dispatch_vk_o,
   output logic [TAG_W-1:0]           dispatch_dest_o,
   output logic [31:0]                dispatch_imm_o,
   output logic [31:0]                dispatch_pc_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   typedef struct packed {
      logic [3:0]       op;
      logic [31:0]      vj;
      logic [31:0]      vk;
      logic [TAG_W-1:0] qj;
      logic [TAG_W-1:0] qk;
      logic [TAG_W-1:0] dest;
      logic [31:0]      imm;
      logic [31:0]      pc;
   } entry_s;

   logic [DEPTH-1:0] busy_q, busy_d;
   entry_s           ent_q [DEPTH];
   entry_s           ent_d [DEPTH];
   // age 0 is the oldest busy entry; ranks stay dense and unique among busy entries
   logic [IW-1:0]    age_q [DEPTH];
   logic [IW-1:0]    age_d [DEPTH];

   logic [DEPTH-1:0] ready;
   logic             sel_found;
   logic [IW-1:0]    sel_idx;
   logic [IW-1:0]    alloc_idx;
   logic             cdb_hit;
   logic             dispatch_fire;
   logic             alloc;
   entry_s           new_ent;
   logic [1:0]       unused_fu_type;

   assign unused_fu_type = issue_packet_i.fu_type;
   assign cdb_hit        = cdb_packet_i.valid && !cdb_packet_i.exception;
   assign full_o         = (count_o == CW'(DEPTH));
   assign dispatch_fire  = dispatch_valid_o && fu_ready_i;
   assign alloc          = issue_valid_i && !full_o && !flush_i;

   always_comb begin
      count_o   = '0;
      ready     = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      alloc_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_o  = count_o + CW'(busy_q[i]);
         ready[i] = busy_q[i] && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
         if (ready[i] && (!sel_found || (age_q[i] < age_q[sel_idx]))) begin
            sel_found = 1'b1;
            sel_idx   = IW'(i);
         end
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy_q[i]) alloc_idx = IW'(i);
      end
   end

   always_comb begin
      dispatch_valid_o = sel_found && !flush_i;
      dispatch_op_o    = '0;
      dispatch_vj_o    = '0;
      dispatch_vk_o    = '0;
      dispatch_dest_o  = '0;
      dispatch_imm_o   = '0;
      dispatch_pc_o    = '0;
      if (dispatch_valid_o) begin
         dispatch_op_o   = ent_q[sel_idx].op;
         dispatch_vj_o   = ent_q[sel_idx].vj;
         dispatch_vk_o   = ent_q[sel_idx].vk;
         dispatch_dest_o = ent_q[sel_idx].dest;
         dispatch_imm_o  = ent_q[sel_idx].imm;
         dispatch_pc_o   = ent_q[sel_idx].pc;
      end
   end

   // an operand produced on the CDB this very cycle is captured on the way in
   always_comb begin
      new_ent.op   = issue_packet_i.op;
      new_ent.vj   = issue_packet_i.vj;
      new_ent.vk   = issue_packet_i.vk;
      new_ent.qj   = issue_packet_i.qj;
      new_ent.qk   = issue_packet_i.qk;
      new_ent.dest = issue_packet_i.dest;
      new_ent.imm  = issue_packet_i.address;
      new_ent.pc   = issue_packet_i.pc;
      if (cdb_hit && (issue_packet_i.qj != '0) && (issue_packet_i.qj == cdb_packet_i.rob_entry)) begin
         new_ent.vj = cdb_packet_i.data;
         new_ent.qj = '0;
      end
      if (cdb_hit && (issue_packet_i.qk != '0) && (issue_packet_i.qk == cdb_packet_i.rob_entry)) begin
         new_ent.vk = cdb_packet_i.data;
         new_ent.qk = '0;
      end
   end

   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         age_d[i] = age_q[i];
         if (busy_q[i] && cdb_hit) begin
            if ((ent_q[i].qj != '0) && (ent_q[i].qj == cdb_packet_i.rob_entry)) begin
               ent_d[i].vj = cdb_packet_i.data;
               ent_d[i].qj = '0;
            end
            if ((ent_q[i].qk != '0) && (ent_q[i].qk == cdb_packet_i.rob_entry)) begin
               ent_d[i].vk = cdb_packet_i.data;
               ent_d[i].qk = '0;
            end
         end
         if (dispatch_fire && busy_q[i] && (age_q[i] > age_q[sel_idx])) begin
            age_d[i] = age_q[i] - IW'(1);
         end
      end
      if (dispatch_fire) busy_d[sel_idx] = 1'b0;
      if (alloc) begin
         busy_d[alloc_idx] = 1'b1;
         ent_d[alloc_idx]  = new_ent;
         age_d[alloc_idx]  = IW'(count_o - CW'(dispatch_fire));
      end
      if (flush_i) busy_d = '0;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         busy_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
            age_q[i] <= '0;
         end
      end else begin
         busy_q <= busy_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
            age_q[i] <= age_d[i];
         end
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - directed scoreboard bench for alu_reservation_station
module tb_alu_reservation_station;
   import alu_reservation_station_pkg::*;

   logic                 clk_i;
   logic                 reset_i;
   logic                 flush_i;
   logic                 issue_valid_i;
   reservation_station_s issue_packet_i;
   logic                 full_o;
   logic [2:0]           count_o;
   cdb_packet_s          cdb_packet_i;
   logic                 fu_ready_i;
   logic                 dispatch_valid_o;
   logic [3:0]           dispatch_op_o;
   logic [31:0]          dispatch_vj_o;
   logic [31:0]          dispatch_vk_o;
   logic [3:0]           dispatch_dest_o;
   logic [31:0]          dispatch_imm_o;
   logic [31:0]          dispatch_pc_o;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] vj;
      logic [31:0] vk;
      logic [3:0]  dest;
      logic [31:0] imm;
      logic [31:0] pc;
   } exp_t;

   exp_t sb [$];
   int   total = 0;
   int   bad   = 0;

   alu_reservation_station #(.DEPTH(4), .TAG_W(4)) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .flush_i          (flush_i),
      .issue_valid_i    (issue_valid_i),
      .issue_packet_i   (issue_packet_i),
      .full_o           (full_o),
      .count_o          (count_o),
      .cdb_packet_i     (cdb_packet_i),
      .fu_ready_i       (fu_ready_i),
      .dispatch_valid_o (dispatch_valid_o),
      .dispatch_op_o    (dispatch_op_o),
      .dispatch_vj_o    (dispatch_vj_o),
      .dispatch_vk_o    (dispatch_vk_o),
      .dispatch_dest_o  (dispatch_dest_o),
      .dispatch_imm_o   (dispatch_imm_o),
      .dispatch_pc_o    (dispatch_pc_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                              input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] dest,
                              input logic [31:0] pc);
      issue_valid_i          = 1'b1;
      issue_packet_i.op      = op;
      issue_packet_i.vj      = vj;
      issue_packet_i.vk      = vk;
      issue_packet_i.qj      = qj;
      issue_packet_i.qk      = qk;
      issue_packet_i.dest    = dest;
      issue_packet_i.address = pc + 32'h1000;
      issue_packet_i.fu_type = 2'd0;
      issue_packet_i.pc      = pc;
   endtask

   task automatic push(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [3:0] dest, input logic [31:0] pc);
      exp_t e;
      e.op = op; e.vj = vj; e.vk = vk; e.dest = dest; e.imm = pc + 32'h1000; e.pc = pc;
      sb.push_back(e);
   endtask

   task automatic drive_cdb(input logic v, input logic [3:0] tag, input logic [31:0] data, input logic exc);
      cdb_packet_i.valid     = v;
      cdb_packet_i.rob_entry = tag;
      cdb_packet_i.data      = data;
      cdb_packet_i.exception = exc;
   endtask

   // sample the handshake mid-cycle, then advance past the next rising edge
   task automatic cyc();
      exp_t e;
      @(negedge clk_i);
      if (dispatch_valid_o && fu_ready_i) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk("disp_op",   32'(dispatch_op_o),   32'(e.op));
            chk("disp_vj",   dispatch_vj_o,        e.vj);
            chk("disp_vk",   dispatch_vk_o,        e.vk);
            chk("disp_dest", 32'(dispatch_dest_o), 32'(e.dest));
            chk("disp_imm",  dispatch_imm_o,       e.imm);
            chk("disp_pc",   dispatch_pc_o,        e.pc);
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 10 && count_o != 3'd0; n++) cyc();
      chk("drain_count", 32'(count_o), 32'd0);
   endtask

   initial begin
      reset_i        = 1'b0;
      flush_i        = 1'b0;
      issue_valid_i  = 1'b0;
      issue_packet_i = '0;
      cdb_packet_i   = '0;
      fu_ready_i     = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_full",  32'(full_o), 32'd0);
      chk("rst_dv",    32'(dispatch_valid_o), 32'd0);
      chk("rst_vj",    dispatch_vj_o, 32'd0);
      reset_i = 1'b1;
      cyc();

      // simple ready ADD
      fu_ready_i = 1'b1;
      drive_issue(4'd1, 32'd5, 32'd7, 4'd0, 4'd0, 4'd1, 32'h100);
      push(4'd1, 32'd5, 32'd7, 4'd1, 32'h100);
      cyc();
      issue_valid_i = 1'b0;
      chk("add_dv",    32'(dispatch_valid_o), 32'd1);
      chk("add_vj",    dispatch_vj_o, 32'd5);
      chk("add_vk",    dispatch_vk_o, 32'd7);
      chk("add_count", 32'(count_o), 32'd1);
      cyc();
      chk("add_count_after", 32'(count_o), 32'd0);
      chk("add_dv_after",    32'(dispatch_valid_o), 32'd0);

      // CDB wakeup, exception ignored
      drive_issue(4'd2, 32'd0, 32'h22, 4'd3, 4'd0, 4'd2, 32'h200);
      push(4'd2, 32'h1234, 32'h22, 4'd2, 32'h200);
      cyc();
      issue_valid_i = 1'b0;
      chk("wait_count", 32'(count_o), 32'd1);
      chk("wait_dv",    32'(dispatch_valid_o), 32'd0);
      drive_cdb(1'b1, 4'd3, 32'hdead, 1'b1);
      cyc();
      drive_cdb(1'b0, 4'd0, 32'd0, 1'b0);
      chk("exc_no_wake", 32'(dispatch_valid_o), 32'd0);
      drive_cdb(1'b1, 4'd3, 32'h1234, 1'b0);
      cyc();
      drive_cdb(1'b0, 4'd0, 32'd0, 1'b0);
      chk("wake_dv", 32'(dispatch_valid_o), 32'd1);
      chk("wake_vj", dispatch_vj_o, 32'h1234);
      cyc();
      chk("wake_count_after", 32'(count_o), 32'd0);

      // same-cycle issue/CDB bypass
      drive_issue(4'd3, 32'd0, 32'd4, 4'd2, 4'd0, 4'd3, 32'h300);
      drive_cdb(1'b1, 4'd2, 32'd9, 1'b0);
      push(4'd3, 32'd9, 32'd4, 4'd3, 32'h300);
      cyc();
      issue_valid_i = 1'b0;
      drive_cdb(1'b0, 4'd0, 32'd0, 1'b0);
      chk("bypass_dv", 32'(dispatch_valid_o), 32'd1);
      chk("bypass_vj", dispatch_vj_o, 32'd9);
      cyc();
      chk("bypass_count_after", 32'(count_o), 32'd0);

      // fill, hold, fifth issue blocked until a slot frees
      fu_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_issue(4'(4 + i), 32'(16 * i + 1), 32'(16 * i + 2), 4'd0, 4'd0, 4'(4 + i), 32'(32'h400 + 16 * i));
         push(4'(4 + i), 32'(16 * i + 1), 32'(16 * i + 2), 4'(4 + i), 32'(32'h400 + 16 * i));
         cyc();
      end
      chk("fill_full",  32'(full_o), 32'd1);
      chk("fill_count", 32'(count_o), 32'd4);
      chk("hold_vj",    dispatch_vj_o, 32'd1);
      drive_issue(4'd8, 32'h81, 32'h82, 4'd0, 4'd0, 4'd8, 32'h480);
      cyc();
      chk("fifth_ignored_count", 32'(count_o), 32'd4);
      chk("fifth_ignored_full",  32'(full_o), 32'd1);
      push(4'd8, 32'h81, 32'h82, 4'd8, 32'h480);
      fu_ready_i = 1'b1;
      cyc();
      chk("free_cycle_count", 32'(count_o), 32'd3);
      chk("free_cycle_full",  32'(full_o), 32'd0);
      cyc();
      issue_valid_i = 1'b0;
      chk("alloc_and_dispatch_count", 32'(count_o), 32'd3);
      drain();

      // younger ready entry overtakes an older waiting one
      drive_issue(4'd9, 32'd0, 32'h91, 4'd5, 4'd0, 4'd9, 32'h500);
      cyc();
      chk("a_waiting_dv", 32'(dispatch_valid_o), 32'd0);
      drive_issue(4'd10, 32'ha1, 32'ha2, 4'd0, 4'd0, 4'd10, 32'h600);
      push(4'd10, 32'ha1, 32'ha2, 4'd10, 32'h600);
      push(4'd9, 32'h55, 32'h91, 4'd9, 32'h500);
      cyc();
      issue_valid_i = 1'b0;
      drive_cdb(1'b1, 4'd5, 32'h55, 1'b0);
      chk("younger_first_op", 32'(dispatch_op_o), 32'd10);
      cyc();
      drive_cdb(1'b0, 4'd0, 32'd0, 1'b0);
      chk("older_next_op", 32'(dispatch_op_o), 32'd9);
      cyc();
      chk("ab_count_after", 32'(count_o), 32'd0);

      // age order survives a freed low slot being reused
      fu_ready_i = 1'b0;
      drive_issue(4'd11, 32'hc1, 32'hc2, 4'd0, 4'd0, 4'd11, 32'h700); push(4'd11, 32'hc1, 32'hc2, 4'd11, 32'h700); cyc();
      drive_issue(4'd12, 32'hd1, 32'hd2, 4'd0, 4'd0, 4'd12, 32'h800); push(4'd12, 32'hd1, 32'hd2, 4'd12, 32'h800); cyc();
      drive_issue(4'd13, 32'he1, 32'he2, 4'd0, 4'd0, 4'd13, 32'h900); push(4'd13, 32'he1, 32'he2, 4'd13, 32'h900); cyc();
      issue_valid_i = 1'b0;
      fu_ready_i = 1'b1;
      cyc();
      fu_ready_i = 1'b0;
      drive_issue(4'd14, 32'hf1, 32'hf2, 4'd0, 4'd0, 4'd14, 32'ha00); push(4'd14, 32'hf1, 32'hf2, 4'd14, 32'ha00);
      cyc();
      issue_valid_i = 1'b0;
      chk("oldest_first_op", 32'(dispatch_op_o), 32'd12);
      fu_ready_i = 1'b1;
      drain();

      // flush overrides issue, CDB and dispatch
      fu_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_issue(4'd15, 32'(32'hb0 + i), 32'd1, 4'd0, 4'(6 + i), 4'd15, 32'hb00);
         cyc();
      end
      issue_valid_i = 1'b0;
      chk("preflush_count", 32'(count_o), 32'd3);
      flush_i = 1'b1;
      fu_ready_i = 1'b1;
      drive_issue(4'd1, 32'd1, 32'd1, 4'd0, 4'd0, 4'd1, 32'hc00);
      drive_cdb(1'b1, 4'd6, 32'h66, 1'b0);
      #1;
      chk("flush_masks_dv", 32'(dispatch_valid_o), 32'd0);
      cyc();
      flush_i = 1'b0;
      issue_valid_i = 1'b0;
      drive_cdb(1'b0, 4'd0, 32'd0, 1'b0);
      fu_ready_i = 1'b0;
      chk("flush_count", 32'(count_o), 32'd0);
      chk("flush_dv",    32'(dispatch_valid_o), 32'd0);

      // asynchronous reset mid-stream
      for (int i = 0; i < 2; i++) begin
         drive_issue(4'd7, 32'hee, 32'hef, 4'd0, 4'd0, 4'd7, 32'hd00);
         cyc();
      end
      issue_valid_i = 1'b0;
      chk("prereset_count", 32'(count_o), 32'd2);
      chk("prereset_dv",    32'(dispatch_valid_o), 32'd1);
      #2;
      reset_i = 1'b0;
      #1;
      chk("async_rst_count", 32'(count_o), 32'd0);
      chk("async_rst_dv",    32'(dispatch_valid_o), 32'd0);
      chk("async_rst_vj",    dispatch_vj_o, 32'd0);
      cyc();
      reset_i = 1'b1;
      fu_ready_i = 1'b1;
      drive_issue(4'd5, 32'h77, 32'h78, 4'd0, 4'd0, 4'd5, 32'he00);
      push(4'd5, 32'h77, 32'h78, 4'd5, 32'he00);
      cyc();
      issue_valid_i = 1'b0;
      chk("post_rst_dv", 32'(dispatch_valid_o), 32'd1);
      chk("post_rst_vj", dispatch_vj_o, 32'h77);
      cyc();
      chk("post_rst_count", 32'(count_o), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
